// File: rtl/ps2_kbmat.sv
// PS/2 keyboard front end: deserialises scan-code set 2 frames, decodes the
// E0/F0/E1 prefixes, looks each key up in an external keymap ROM and keeps
// the 64-bit Z88 key matrix up to date.
module ps2_kbmat #(
    parameter int          FILT = 8,
    parameter logic [15:0] TOUT = 16'd9830
) (
    input  logic        mck,
    input  logic        rin,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [8:0]  km_code,
    input  logic [5:0]  km_idx,
    input  logic        km_hit,
    output logic [63:0] kbmat,
    output logic        key_evt,
    output logic        frm_err
);

    localparam int FCW = $clog2(FILT) + 1;

    typedef enum logic [1:0] {R_IDLE, R_DATA, R_PAR, R_STOP} rst_t;
    typedef enum logic [1:0] {D_NONE, D_LOOK, D_SKIP} dst_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0]     r_cs, r_ds;
    logic           r_fclk;
    logic [FCW-1:0] r_fcnt;
    logic           w_cs, w_dat, w_fall;

    assign w_cs  = r_cs[1];
    assign w_dat = r_ds[1];
    // Accepted falling edge: the filtered clock is about to drop this cycle.
    assign w_fall = r_fclk && !w_cs && (r_fcnt == FCW'(FILT - 1));

    // Two-stage synchronisers plus a level filter on the PS/2 clock.
    always_ff @(posedge mck) begin
        if (rin) begin
            r_cs   <= 2'b11;
            r_ds   <= 2'b11;
            r_fclk <= 1'b1;
            r_fcnt <= '0;
        end else begin
            r_cs <= {r_cs[0], ps2_clk};
            r_ds <= {r_ds[0], ps2_dat};
            if (w_cs == r_fclk) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FCW'(FILT - 1)) begin
                r_fclk <= w_cs;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rst_t        r_rst, w_rnxt;
    logic [2:0]  r_bcnt;
    logic [7:0]  r_shift;
    logic        r_par;
    logic [15:0] r_tcnt;
    logic        r_strb, r_ferr;
    logic        w_strb, w_err, w_tout;

    assign w_tout = (r_tcnt == TOUT - 16'd1);

    // Receiver next state, byte strobe and error decision.
    always_comb begin
        w_rnxt = r_rst;
        w_strb = 1'b0;
        w_err  = 1'b0;
        case (r_rst)
            R_IDLE: if (w_fall && !w_dat) w_rnxt = R_DATA;
            R_DATA: begin
                if (w_fall) begin
                    if (r_bcnt == 3'd7) w_rnxt = R_PAR;
                end else if (w_tout) begin
                    w_rnxt = R_IDLE;
                    w_err  = 1'b1;
                end
            end
            R_PAR: begin
                if (w_fall) begin
                    w_rnxt = R_STOP;
                end else if (w_tout) begin
                    w_rnxt = R_IDLE;
                    w_err  = 1'b1;
                end
            end
            R_STOP: begin
                if (w_fall) begin
                    w_rnxt = R_IDLE;
                    if (w_dat && (^{r_shift, r_par})) w_strb = 1'b1;
                    else                              w_err  = 1'b1;
                end else if (w_tout) begin
                    w_rnxt = R_IDLE;
                    w_err  = 1'b1;
                end
            end
            default: w_rnxt = R_IDLE;
        endcase
    end

    // Receiver state, shift register and inactivity counter.
    always_ff @(posedge mck) begin
        if (rin) begin
            r_rst   <= R_IDLE;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tcnt  <= '0;
            r_strb  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_rst  <= w_rnxt;
            r_strb <= w_strb;
            r_ferr <= w_err;
            if (r_rst == R_IDLE || w_fall) r_tcnt <= '0;
            else                           r_tcnt <= r_tcnt + 16'd1;
            if (r_rst == R_IDLE && w_fall) r_bcnt <= '0;
            if (r_rst == R_DATA && w_fall) begin
                r_shift <= {w_dat, r_shift[7:1]};
                r_bcnt  <= r_bcnt + 3'd1;
            end
            if (r_rst == R_PAR && w_fall) r_par <= w_dat;
        end
    end

    // ------------------------------------------------------------------
    // Decoder and matrix
    // ------------------------------------------------------------------
    dst_t        r_dst, w_dnxt;
    logic        r_ext, r_brk;
    logic [2:0]  r_scnt;
    logic [8:0]  r_code;
    logic [63:0] r_kbmat;
    logic        r_chg;
    logic        w_e0, w_f0, w_e1, w_ovr, w_bat, w_look;

    // r_shift holds the completed byte while r_strb is high; the next frame
    // is at least a millisecond away.
    assign w_e0   = (r_shift == 8'hE0);
    assign w_f0   = (r_shift == 8'hF0);
    assign w_e1   = (r_shift == 8'hE1);
    assign w_ovr  = (r_shift == 8'h00) || (r_shift == 8'hFF);
    assign w_bat  = (r_shift == 8'hAA) && !r_ext && !r_brk;
    assign w_look = r_strb && !(w_e0 || w_f0 || w_e1 || w_ovr || w_bat);

    // Decoder next state.
    always_comb begin
        w_dnxt = r_dst;
        case (r_dst)
            D_NONE: begin
                if (r_strb && w_e1) w_dnxt = D_SKIP;
                else if (w_look)    w_dnxt = D_LOOK;
            end
            D_LOOK: w_dnxt = D_NONE;
            D_SKIP: if (r_strb && r_scnt == 3'd1) w_dnxt = D_NONE;
            default: w_dnxt = D_NONE;
        endcase
    end

    // Prefix flags, keymap address, matrix update and change detection.
    always_ff @(posedge mck) begin
        if (rin) begin
            r_dst   <= D_NONE;
            r_ext   <= 1'b0;
            r_brk   <= 1'b0;
            r_scnt  <= '0;
            r_code  <= '0;
            r_kbmat <= '0;
            r_chg   <= 1'b0;
        end else begin
            r_dst <= w_dnxt;
            r_chg <= 1'b0;
            case (r_dst)
                D_NONE: begin
                    if (r_strb) begin
                        if (w_e0) begin
                            r_ext <= 1'b1;
                        end else if (w_f0) begin
                            r_brk <= 1'b1;
                        end else if (w_ovr) begin
                            r_kbmat <= '0;
                            r_chg   <= |r_kbmat;
                            r_ext   <= 1'b0;
                            r_brk   <= 1'b0;
                        end else if (w_e1) begin
                            r_scnt <= 3'd7;
                            r_ext  <= 1'b0;
                            r_brk  <= 1'b0;
                        end else if (w_look) begin
                            r_code <= {r_ext, r_shift};
                        end
                    end
                end
                D_LOOK: begin
                    // The ROM answers combinationally from r_code this cycle.
                    if (km_hit) begin
                        r_kbmat[km_idx] <= ~r_brk;
                        r_chg           <= r_kbmat[km_idx] ^ ~r_brk;
                    end
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
                D_SKIP: if (r_strb) r_scnt <= r_scnt - 3'd1;
                default: ;
            endcase
        end
    end

    assign km_code = r_code;
    assign kbmat   = r_kbmat;
    assign key_evt = r_chg;
    assign frm_err = r_ferr;

endmodule
